rst_mgmt_eth: RTL and testbench

RST_MGMT_ETH -- requirements
Module: rst_mgmt_eth

---
 rtl/rst_mgmt_eth.sv | 128 ++++++++++++
 tb/tb_rst_mgmt_eth.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rst_mgmt_eth.sv
// ============================================================================
// Module   : rst_mgmt_eth
// Brief    : Ethernet-domain reset sequencer driven by the MMCM lock signal.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rst_mgmt_eth #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_FILTER_CYCLES = 16,
    parameter int RST_HOLD_CYCLES    = 64
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       clk_locked_in,
    input  logic       lost_clr,
    output logic       rst_eth_out,
    output logic       rst_eth_n_out,
    output logic       eth_ready,
    output logic       lock_lost,
    output logic [7:0] lock_lost_cnt
);

    localparam int c_MAX = (LOCK_FILTER_CYCLES > RST_HOLD_CYCLES) ? LOCK_FILTER_CYCLES
                                                                   : RST_HOLD_CYCLES;
    localparam int c_CW  = $clog2(c_MAX + 1);
    // The WAIT_LOCK cycle that first sees lock is the first filtered cycle.
    localparam logic [c_CW-1:0] c_FILT_LAST = c_CW'((LOCK_FILTER_CYCLES >= 2) ?
                                                    (LOCK_FILTER_CYCLES - 2) : 0);
    localparam logic [c_CW-1:0] c_HOLD_LAST = c_CW'(RST_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_FILTER    = 2'd1,
        S_HOLD      = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CW-1:0]        r_cnt;
    logic [c_CW-1:0]        w_cnt_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_locked_s;
    logic                   w_loss;

    assign w_locked_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_loss      = 1'b0;
        case (r_state)
            S_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = (LOCK_FILTER_CYCLES == 1) ? S_HOLD : S_FILTER;
                    w_cnt_nxt   = '0;
                end
            end
            S_FILTER: begin
                if (!w_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_FILT_LAST) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (!w_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_HOLD_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_loss      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= S_WAIT_LOCK;
            r_cnt         <= '0;
            r_sync        <= '0;
            rst_eth_out   <= 1'b1;
            rst_eth_n_out <= 1'b0;
            eth_ready     <= 1'b0;
            lock_lost     <= 1'b0;
            lock_lost_cnt <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_sync        <= {r_sync[SYNC_STAGES-2:0], clk_locked_in};
            rst_eth_out   <= (w_state_nxt != S_RUN);
            rst_eth_n_out <= (w_state_nxt == S_RUN);
            eth_ready     <= (w_state_nxt == S_RUN);
            // A loss on the same edge as a clear wins and restarts the count at one.
            if (w_loss) begin
                lock_lost     <= 1'b1;
                lock_lost_cnt <= lost_clr ? 8'd1 :
                                 ((lock_lost_cnt == 8'hFF) ? lock_lost_cnt
                                                           : lock_lost_cnt + 8'd1);
            end else if (lost_clr) begin
                lock_lost     <= 1'b0;
                lock_lost_cnt <= 8'd0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rst_mgmt_eth.sv
// ============================================================================
// Module   : tb_rst_mgmt_eth
// Brief    : Self-checking bench for rst_mgmt_eth against a lock-history model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rst_mgmt_eth;

    localparam int SYNC = 2;
    localparam int LF   = 16;
    localparam int RH   = 64;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       clk_locked_in = 1'b0;
    logic       lost_clr = 1'b0;
    logic       rst_eth_out;
    logic       rst_eth_n_out;
    logic       eth_ready;
    logic       lock_lost;
    logic [7:0] lock_lost_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Model: locked_s seen at an edge is the input sampled SYNC edges earlier;
    // RUN is reached once LF+RH consecutive high locked_s values were seen.
    bit q_sync[$];
    int m_run_cnt;
    bit m_lost;
    int m_cnt;

    rst_mgmt_eth #(
        .SYNC_STAGES        (SYNC),
        .LOCK_FILTER_CYCLES (LF),
        .RST_HOLD_CYCLES    (RH)
    ) u_dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .clk_locked_in (clk_locked_in),
        .lost_clr      (lost_clr),
        .rst_eth_out   (rst_eth_out),
        .rst_eth_n_out (rst_eth_n_out),
        .eth_ready     (eth_ready),
        .lock_lost     (lock_lost),
        .lock_lost_cnt (lock_lost_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit lk, input bit clr);
        bit ls;
        bit was_run;
        if (r) begin
            q_sync.delete();
            for (int i = 0; i < SYNC; i++) q_sync.push_back(1'b0);
            m_run_cnt = 0;
            m_lost    = 1'b0;
            m_cnt     = 0;
        end else begin
            ls      = q_sync[0];
            was_run = (m_run_cnt >= LF + RH);
            if (ls) m_run_cnt = (m_run_cnt < 100000) ? m_run_cnt + 1 : m_run_cnt;
            else    m_run_cnt = 0;
            if (was_run && !ls) begin
                m_lost = 1'b1;
                m_cnt  = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            end else if (clr) begin
                m_lost = 1'b0;
                m_cnt  = 0;
            end
            void'(q_sync.pop_front());
            q_sync.push_back(lk);
        end
    endtask

    task automatic cyc(input bit r, input bit lk, input bit clr);
        bit run;
        rst_in        = r;
        clk_locked_in = lk;
        lost_clr      = clr;
        @(posedge clk_in);
        model_edge(r, lk, clr);
        #1;
        run = (m_run_cnt >= LF + RH);
        chk("rst_eth_out",   32'(rst_eth_out),   32'(!run));
        chk("rst_eth_n_out", 32'(rst_eth_n_out), 32'(run));
        chk("eth_ready",     32'(eth_ready),     32'(run));
        chk("lock_lost",     32'(lock_lost),     32'(m_lost));
        chk("lock_lost_cnt", 32'(lock_lost_cnt), 32'(m_cnt));
    endtask

    task automatic lose_relock(input int low_cycles);
        for (int i = 0; i < low_cycles; i++) cyc(0, 0, 0);
        for (int i = 0; i < SYNC + LF + RH + 2; i++) cyc(0, 1, 0);
    endtask

    initial begin
        for (int i = 0; i < SYNC; i++) q_sync.push_back(1'b0);
        m_run_cnt = 0;
        m_lost    = 1'b0;
        m_cnt     = 0;

        // Power-up and nominal lock latency
        for (int i = 0; i < 4; i++) cyc(1, 0, 0);
        chk("reset_rst_out", 32'(rst_eth_out), 32'd1);
        chk("reset_ready",   32'(eth_ready),   32'd0);
        for (int e = 1; e <= 90; e++) begin
            cyc(0, 1, 0);
            if (e == 81) chk("edge81_rst_out", 32'(rst_eth_out), 32'd1);
            if (e == 82) chk("edge82_ready",   32'(eth_ready),   32'd1);
        end
        chk("powerup_lost", 32'(lock_lost), 32'd0);

        // Loss in RUN: reset rises two edges after the sampled fall
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("loss_edge1_ready", 32'(eth_ready), 32'd1);
        cyc(0, 0, 0);
        chk("loss_edge2_rst", 32'(rst_eth_out), 32'd1);
        chk("loss_cnt1",      32'(lock_lost_cnt), 32'd1);
        lose_relock(0);

        // Glitch in FILTER
        cyc(1, 0, 0);
        for (int e = 1; e <= 9; e++) cyc(0, 1, 0);
        cyc(0, 0, 0);
        for (int e = 1; e <= 90; e++) begin
            cyc(0, 1, 0);
            if (e == 81) chk("glitch_edge81_rst", 32'(rst_eth_out), 32'd1);
        end
        chk("glitch_cnt", 32'(lock_lost_cnt), 32'd0);

        // Clear with count 5, then clear coincident with a loss
        for (int k = 0; k < 5; k++) lose_relock(2);
        chk("cnt_before_clr", 32'(lock_lost_cnt), 32'd5);
        cyc(0, 1, 1);
        chk("clr_cnt",  32'(lock_lost_cnt), 32'd0);
        chk("clr_lost", 32'(lock_lost),     32'd0);
        lose_relock(1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        chk("coinc_cnt",  32'(lock_lost_cnt), 32'd1);
        chk("coinc_lost", 32'(lock_lost),     32'd1);
        lose_relock(0);

        // Reset mid-HOLD
        cyc(1, 0, 0);
        for (int e = 1; e < 40; e++) cyc(0, 1, 0);
        cyc(1, 1, 1);
        chk("midhold_rst_out", 32'(rst_eth_out), 32'd1);
        chk("midhold_cnt",     32'(lock_lost_cnt), 32'd0);
        for (int e = 1; e <= 90; e++) cyc(0, 1, 0);

        // Saturation
        for (int k = 0; k < 300; k++) lose_relock(1);
        chk("sat_cnt", 32'(lock_lost_cnt), 32'd255);

        // Randomized lock behaviour, clears and occasional resets
        begin
            bit lk;
            lk = 1'b1;
            for (int i = 0; i < 6000; i++) begin
                if ($urandom_range(0, 99) < 2) lk = ~lk;
                cyc(($urandom_range(0, 999) < 3), lk, ($urandom_range(0, 99) < 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
